// File: rtl/mac_rx_framer.sv
// mac_rx_framer
//   Strips preamble/SFD from RGMII receive bytes, delays the stream by four
//   bytes so the FCS is never forwarded, checks CRC-32 and frame length,
//   and keeps saturating good/bad frame counters.
//
// Ports
//   i_clk        byte clock, rising edge
//   i_rst        synchronous active-high reset
//   i_rx_data    received byte
//   i_rx_valid   i_rx_data valid this cycle
//   i_rx_end     high while the line is idle, low throughout a frame
//   o_data       payload byte
//   o_valid      o_data valid (single-cycle pulse per byte)
//   o_last       final payload byte, qualified by o_valid
//   o_crc_err    FCS mismatch, qualified by o_valid & o_last
//   o_len_err    length out of range, qualified by o_valid & o_last
//   o_good_cnt   saturating count of error-free frames
//   o_bad_cnt    saturating count of errored/dropped frames

module mac_rx_framer #(
  parameter int unsigned P_MIN_LEN = 64,
  parameter int unsigned P_MAX_LEN = 1518
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  input  logic        i_rx_end,
  output logic [7:0]  o_data,
  output logic        o_valid,
  output logic        o_last,
  output logic        o_crc_err,
  output logic        o_len_err,
  output logic [15:0] o_good_cnt,
  output logic [15:0] o_bad_cnt
);

  localparam logic [31:0] CRC_INIT    = '1;
  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
  localparam logic [10:0] LEN_SAT     = '1;

  typedef enum logic [1:0] {
    IDLE,
    PREAMBLE,
    DATA,
    DROP
  } state_t;

  state_t state, state_nxt;

  logic        armed;
  logic        accept;

  logic [31:0] crc, crc_nxt;
  logic [10:0] len, len_nxt;
  logic [31:0] win, win_nxt;          // win[31:24] is the oldest byte
  logic [2:0]  win_cnt, win_cnt_nxt;
  logic [7:0]  hold, hold_nxt;
  logic        hold_full, hold_full_nxt;

  logic [7:0]  data_nxt;
  logic        valid_nxt, last_nxt, crc_err_nxt, len_err_nxt;
  logic [15:0] good_nxt, bad_nxt;

  logic [31:0] crc_rev;
  logic        crc_bad, len_bad;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                             input logic [7:0]  d);
    logic [31:0] c;
    c = crc_in ^ {24'd0, d};
    for (int unsigned i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

  assign accept = i_rx_valid & ~i_rx_end;

  // The register runs LSB-first; the residue constant is written MSB-first,
  // so compare against the bit-reversed register.
  assign crc_rev = {<<{crc}};
  assign crc_bad = (crc_rev != CRC_RESIDUE);
  assign len_bad = (32'(len) < P_MIN_LEN) || (32'(len) > P_MAX_LEN);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        // Until idle has been seen once, bytes belong to a frame that was
        // already in flight when reset released.
        if (armed && accept) begin
          if (i_rx_data == 8'h55)      state_nxt = PREAMBLE;
          else if (i_rx_data == 8'hD5) state_nxt = DATA;
          else                         state_nxt = DROP;
        end
      end
      PREAMBLE: begin
        if (i_rx_end) begin
          state_nxt = IDLE;
        end else if (accept) begin
          if (i_rx_data == 8'hD5)      state_nxt = DATA;
          else if (i_rx_data != 8'h55) state_nxt = DROP;
        end
      end
      DATA: begin
        if (i_rx_end) state_nxt = IDLE;
      end
      DROP: begin
        if (i_rx_end) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output / datapath next-value logic
  always_comb begin
    crc_nxt       = crc;
    len_nxt       = len;
    win_nxt       = win;
    win_cnt_nxt   = win_cnt;
    hold_nxt      = hold;
    hold_full_nxt = hold_full;
    data_nxt      = o_data;
    valid_nxt     = 1'b0;
    last_nxt      = 1'b0;
    crc_err_nxt   = 1'b0;
    len_err_nxt   = 1'b0;
    good_nxt      = o_good_cnt;
    bad_nxt       = o_bad_cnt;

    if (state != DATA && state_nxt == DATA) begin
      crc_nxt       = CRC_INIT;
      len_nxt       = '0;
      win_cnt_nxt   = '0;
      hold_full_nxt = 1'b0;
    end

    unique case (state)
      DATA: begin
        if (i_rx_end) begin
          hold_full_nxt = 1'b0;
          if (hold_full) begin
            data_nxt    = hold;
            valid_nxt   = 1'b1;
            last_nxt    = 1'b1;
            crc_err_nxt = crc_bad;
            len_err_nxt = len_bad;
            if (crc_bad || len_bad) bad_nxt  = sat_inc(o_bad_cnt);
            else                    good_nxt = sat_inc(o_good_cnt);
          end else begin
            bad_nxt = sat_inc(o_bad_cnt);
          end
        end else if (accept) begin
          crc_nxt = crc32_byte(crc, i_rx_data);
          len_nxt = (len == LEN_SAT) ? len : len + 11'd1;
          win_nxt = {win[23:0], i_rx_data};
          if (win_cnt == 3'd4) begin
            // Window full: oldest byte moves to hold; the byte it displaces
            // is now known not to be FCS and goes out.
            if (hold_full) begin
              data_nxt  = hold;
              valid_nxt = 1'b1;
            end
            hold_nxt      = win[31:24];
            hold_full_nxt = 1'b1;
          end else begin
            win_cnt_nxt = win_cnt + 3'd1;
          end
        end
      end
      DROP: begin
        if (i_rx_end) bad_nxt = sat_inc(o_bad_cnt);
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      armed      <= 1'b0;
      crc        <= '0;
      len        <= '0;
      win        <= '0;
      win_cnt    <= '0;
      hold       <= '0;
      hold_full  <= 1'b0;
      o_data     <= '0;
      o_valid    <= 1'b0;
      o_last     <= 1'b0;
      o_crc_err  <= 1'b0;
      o_len_err  <= 1'b0;
      o_good_cnt <= '0;
      o_bad_cnt  <= '0;
    end else begin
      if (i_rx_end) armed <= 1'b1;
      crc        <= crc_nxt;
      len        <= len_nxt;
      win        <= win_nxt;
      win_cnt    <= win_cnt_nxt;
      hold       <= hold_nxt;
      hold_full  <= hold_full_nxt;
      o_data     <= data_nxt;
      o_valid    <= valid_nxt;
      o_last     <= last_nxt;
      o_crc_err  <= crc_err_nxt;
      o_len_err  <= len_err_nxt;
      o_good_cnt <= good_nxt;
      o_bad_cnt  <= bad_nxt;
    end
  end

endmodule

// File: tb/tb_mac_rx_framer.sv
// tb_mac_rx_framer
//   Self-checking bench for mac_rx_framer. Frames are built as byte queues,
//   expected beats and counters come from a frame-level reference model
//   (serial CRC over the payload, length from byte count).

module tb_mac_rx_framer;

  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 1518;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_end;
  logic [7:0]  o_data;
  logic        o_valid, o_last, o_crc_err, o_len_err;
  logic [15:0] o_good_cnt, o_bad_cnt;

  always #5 clk = ~clk;

  mac_rx_framer #(
    .P_MIN_LEN(MIN_LEN),
    .P_MAX_LEN(MAX_LEN)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_rx_data (rx_data),
    .i_rx_valid(rx_valid),
    .i_rx_end  (rx_end),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .o_last    (o_last),
    .o_crc_err (o_crc_err),
    .o_len_err (o_len_err),
    .o_good_cnt(o_good_cnt),
    .o_bad_cnt (o_bad_cnt)
  );

  int errors = 0;
  int checks = 0;
  int proto_err = 0;
  int exp_good = 0;
  int exp_bad  = 0;

  // beat = {data, last, crc_err, len_err}
  logic [10:0] got_q[$];
  logic [10:0] exp_q[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  body_q[$];

  // Monitor: sample 1 time unit after the active edge.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      got_q.delete();
    end else if (o_valid) begin
      got_q.push_back({o_data, o_last, o_crc_err, o_len_err});
    end else if (o_last || o_crc_err || o_len_err) begin
      proto_err++;
    end
  end

  // Ethernet FCS over the first k bytes of body_q, bit-serial form.
  function automatic logic [31:0] ref_crc(input int k);
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < k; i++) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ body_q[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return ~c;
  endfunction

  // body_q = payload + FCS (LSB first); tx_q = preamble + SFD + body.
  task automatic make_frame(input int pre, input int npay, input bit ramp, input bit corrupt);
    logic [31:0] fcs;
    body_q.delete();
    for (int i = 0; i < npay; i++) body_q.push_back(ramp ? 8'(i) : 8'($urandom));
    fcs = ref_crc(npay);
    if (corrupt) fcs[0] = ~fcs[0];
    for (int i = 0; i < 4; i++) body_q.push_back(fcs[8*i +: 8]);
    tx_q.delete();
    for (int i = 0; i < pre; i++) tx_q.push_back(8'h55);
    tx_q.push_back(8'hD5);
    foreach (body_q[i]) tx_q.push_back(body_q[i]);
  endtask

  // Reference model for a frame whose preamble/SFD is well formed.
  task automatic predict_frame();
    int          n;
    logic [31:0] fcs_rx;
    logic        ce, le;
    n = body_q.size();
    exp_q.delete();
    if (n < 5) begin
      exp_bad++;
    end else begin
      fcs_rx = {body_q[n-1], body_q[n-2], body_q[n-3], body_q[n-4]};
      ce = (ref_crc(n - 4) != fcs_rx);
      le = (n < MIN_LEN) || (n > MAX_LEN);
      for (int i = 0; i < n - 4; i++) begin
        if (i == n - 5) exp_q.push_back({body_q[i], 1'b1, ce, le});
        else            exp_q.push_back({body_q[i], 3'b000});
      end
      if (ce || le) exp_bad++;
      else          exp_good++;
    end
  endtask

  task automatic drive_frame(input bit slow, input int reset_at, input bit lead_idle);
    if (lead_idle) begin
      // Valid byte during idle must be ignored.
      @(negedge clk);
      rx_end = 1'b1; rx_valid = 1'b1; rx_data = 8'h55;
    end
    foreach (tx_q[i]) begin
      @(negedge clk);
      rx_end = 1'b0; rx_valid = 1'b1; rx_data = tx_q[i];
      rst = (i == reset_at);
      if (slow) begin
        @(negedge clk);
        rx_valid = 1'b0; rst = 1'b0; rx_data = 8'($urandom);
      end
    end
    @(negedge clk);
    rx_valid = 1'b0; rx_end = 1'b1; rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  function automatic int first_diff();
    int m;
    m = (got_q.size() > exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) begin
      if (i >= got_q.size() || i >= exp_q.size()) return i;
      if (got_q[i] !== exp_q[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [10:0] beat_at(input bit from_exp, input int i);
    if (from_exp) return (i < exp_q.size()) ? exp_q[i] : 11'h7FF;
    return (i < got_q.size()) ? got_q[i] : 11'h7FF;
  endfunction

  task automatic test_reset();
    int d;
    rst = 1'b1; rx_end = 1'b0; rx_valid = 1'b0; rx_data = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_data, o_valid, o_last, o_crc_err, o_len_err, o_good_cnt, o_bad_cnt} !== 44'd0) begin
      errors++;
      $display("FAIL reset_outputs: got data=%h v=%b l=%b ce=%b le=%b good=%0d bad=%0d required all 0",
               o_data, o_valid, o_last, o_crc_err, o_len_err, o_good_cnt, o_bad_cnt);
    end
    // Frame in flight at reset release: never armed, so ignored entirely.
    make_frame(7, 60, 1'b1, 1'b0);
    exp_q.delete();
    drive_frame(1'b0, -1, 1'b0);
    checks++;
    d = first_diff();
    if (d != -1) begin
      errors++;
      $display("FAIL unarmed_beats: got %0d beats required %0d", got_q.size(), exp_q.size());
    end
    checks++;
    if (o_good_cnt !== 16'(exp_good) || o_bad_cnt !== 16'(exp_bad)) begin
      errors++;
      $display("FAIL unarmed_counts: got good=%0d bad=%0d required good=%0d bad=%0d",
               o_good_cnt, o_bad_cnt, exp_good, exp_bad);
    end
  endtask

  task automatic run_and_check(input string name, input bit slow);
    int d;
    got_q.delete();
    drive_frame(slow, -1, 1'b1);
    checks++;
    d = first_diff();
    if (d != -1) begin
      errors++;
      $display("FAIL %s beats: got %0d beats required %0d; beat %0d got=%h required=%h",
               name, got_q.size(), exp_q.size(), d, beat_at(1'b0, d), beat_at(1'b1, d));
    end
    checks++;
    if (o_good_cnt !== 16'(exp_good)) begin
      errors++;
      $display("FAIL %s good_cnt: got %0d required %0d", name, o_good_cnt, exp_good);
    end
    checks++;
    if (o_bad_cnt !== 16'(exp_bad)) begin
      errors++;
      $display("FAIL %s bad_cnt: got %0d required %0d", name, o_bad_cnt, exp_bad);
    end
  endtask

  task automatic test_good_frame();
    make_frame(7, 60, 1'b1, 1'b0);
    predict_frame();
    run_and_check("good_gig", 1'b0);
  endtask

  task automatic test_crc_error();
    make_frame(7, 60, 1'b1, 1'b1);
    predict_frame();
    run_and_check("crc_err", 1'b0);
  endtask

  task automatic test_slow_rate();
    make_frame(7, 60, 1'b1, 1'b0);
    predict_frame();
    run_and_check("good_slow", 1'b1);
  endtask

  task automatic test_runt();
    make_frame(7, 16, 1'b1, 1'b0);
    predict_frame();
    run_and_check("runt", 1'b0);
  endtask

  task automatic test_bad_preamble();
    tx_q.delete();
    tx_q.push_back(8'h55); tx_q.push_back(8'h55); tx_q.push_back(8'h00);
    for (int i = 0; i < 20; i++) tx_q.push_back(8'($urandom));
    exp_q.delete();
    exp_bad++;
    run_and_check("bad_preamble", 1'b0);
    make_frame(7, 60, 1'b1, 1'b0);
    predict_frame();
    run_and_check("after_drop", 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    int d;
    make_frame(7, 60, 1'b1, 1'b0);
    exp_q.delete();
    exp_good = 0;
    exp_bad  = 0;
    drive_frame(1'b0, 29, 1'b1);
    checks++;
    d = first_diff();
    if (d != -1) begin
      errors++;
      $display("FAIL reset_mid beats: got %0d beats required 0", got_q.size());
    end
    checks++;
    if (o_good_cnt !== 16'd0 || o_bad_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid counts: got good=%0d bad=%0d required 0/0", o_good_cnt, o_bad_cnt);
    end
    make_frame(7, 60, 1'b1, 1'b0);
    predict_frame();
    run_and_check("after_reset", 1'b0);
  endtask

  task automatic test_length_boundary();
    int pays[6] = '{0, 1, MIN_LEN - 5, MIN_LEN - 4, MAX_LEN - 4, MAX_LEN - 3};
    foreach (pays[i]) begin
      make_frame(7, pays[i], 1'b0, 1'b0);
      predict_frame();
      run_and_check($sformatf("len_%0d", pays[i] + 4), 1'b0);
    end
  endtask

  task automatic test_random();
    int          kind, pre, npay;
    bit          slow;
    logic [7:0]  bad;
    for (int n = 0; n < 14; n++) begin
      kind = $urandom_range(0, 5);
      slow = 1'($urandom_range(0, 1));
      pre  = $urandom_range(0, 7);
      if (kind == 0) begin
        do bad = 8'($urandom); while (bad == 8'h55 || bad == 8'hD5);
        tx_q.delete();
        for (int i = 0; i < pre; i++) tx_q.push_back(8'h55);
        tx_q.push_back(bad);
        for (int i = 0; i < 10; i++) tx_q.push_back(8'($urandom));
        exp_q.delete();
        exp_bad++;
      end else begin
        npay = $urandom_range(0, 90);
        make_frame(pre, npay, 1'b0, kind == 1);
        predict_frame();
      end
      run_and_check($sformatf("rand%0d", n), slow);
    end
  endtask

  task automatic test_valid_qualification();
    checks++;
    if (proto_err !== 0) begin
      errors++;
      $display("FAIL flag_qualify: got %0d cycles with flags set while o_valid=0 required 0", proto_err);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_crc_error();
    test_slow_rate();
    test_runt();
    test_bad_preamble();
    test_reset_mid_frame();
    test_length_boundary();
    test_random();
    test_valid_qualification();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mac_rx_framer.md
MAC_RX_FRAMER -- requirements
Module: mac_rx_framer

Interface
REQ-001 SHALL have parameter P_MIN_LEN, default 64, the minimum frame length in bytes from the destination address to the FCS inclusive.
REQ-002 SHALL have parameter P_MAX_LEN, default 1518, the maximum frame length in bytes from the destination address to the FCS inclusive.
REQ-003 i_clk  in  1  single clock (RGMII rx-derived byte clock); all logic on rising edge.
REQ-004 i_rst  in  1  reset, synchronous, active-high.
REQ-005 i_rx_data  in  8  received byte from RGMII front end.
REQ-006 i_rx_valid  in  1  i_rx_data valid this cycle; gig = continuous, 10/100 = at most every other cycle.
REQ-007 i_rx_end  in  1  level, high while RX_CTL idle (no frame); low throughout a frame.
REQ-008 o_data  out  8  payload byte (preamble/SFD/FCS stripped).
REQ-009 o_valid  out  1  o_data valid; no backpressure.
REQ-010 o_last  out  1  final payload byte of frame, qualified by o_valid.
REQ-011 o_crc_err  out  1  FCS mismatch, qualified by o_valid&o_last.
REQ-012 o_len_err  out  1  length outside [P_MIN_LEN,P_MAX_LEN], qualified by o_valid&o_last.
REQ-013 o_good_cnt  out  16  saturating count of frames ending without error.
REQ-014 o_bad_cnt  out  16  saturating count of errored/dropped frames.

Function
REQ-015 States SHALL be IDLE, PREAMBLE, DATA, DROP; all outputs registered.
REQ-016 Byte accepted only when i_rx_valid=1 and i_rx_end=0; i_rx_valid with i_rx_end=1 ignored.
REQ-017 IDLE: accepted 0x55 -> PREAMBLE; 0xD5 -> DATA; any other byte -> DROP.
REQ-018 PREAMBLE: 0x55 stays; 0xD5 -> DATA; other byte -> DROP; i_rx_end=1 -> IDLE, no output, no counter change.
REQ-019 On entry to DATA: CRC register = 0xFFFFFFFF, length counter = 0, holding register empty.
REQ-020 DATA: each accepted byte updates CRC-32 (IEEE 802.3, reflected, poly 0xEDB88320) and length counter (11 bits, saturates at 2047).
REQ-021 Accepted bytes enter a 4-byte FCS window; the byte shifted out loads a 1-byte hold register.
REQ-022 When the hold register is full and is replaced, the prior held byte SHALL emit on the next cycle with o_valid=1, o_last=0.
REQ-023 First cycle of i_rx_end=1 in DATA: next cycle emits held byte with o_valid=1, o_last=1, error flags set; FSM -> IDLE.
REQ-024 o_crc_err=1 iff final CRC register != 0xC704DD7B (residue over data+FCS).
REQ-025 o_len_err=1 iff length counter < P_MIN_LEN or > P_MAX_LEN.
REQ-026 Frame with <5 bytes after SFD (hold empty at end): no beat emitted; o_bad_cnt +1.
REQ-027 DROP: discard bytes until i_rx_end=1, then -> IDLE, o_bad_cnt +1.
REQ-028 Frame end: o_good_cnt +1 if no error flag set, else o_bad_cnt +1; both counters saturate at 0xFFFF.
REQ-029 o_valid SHALL be a single-cycle pulse per emitted byte; o_last, o_crc_err and o_len_err SHALL be 0 whenever o_valid=0.

Reset
REQ-030 During i_rst: FSM=IDLE; o_data=0, o_valid=0, o_last=0, o_crc_err=0, o_len_err=0, o_good_cnt=0, o_bad_cnt=0; hold/window cleared.
REQ-031 After reset, IDLE SHALL not accept bytes until i_rx_end=1 observed at least one cycle (armed flag), so a frame in progress at reset release is ignored entirely.
REQ-032 Reset mid-frame SHALL abort with no o_last beat and no counter update.

Verification
REQ-033 Gig: 7x0x55, 0xD5, 60 payload bytes 0x00..0x3B, correct FCS, then i_rx_end=1 -> 60 beats 0x00..0x3B; o_last on 0x3B; errors 0; o_good_cnt=1.
REQ-034 Same frame with FCS bit 0 flipped -> 60 beats; last beat o_crc_err=1, o_len_err=0; o_bad_cnt=1.
REQ-035 Same good frame with i_rx_valid every other cycle (10/100) -> identical 60-byte output; o_good_cnt=1.
REQ-036 Runt: 16 payload + valid FCS (20 bytes) -> 16 beats; last o_len_err=1, o_crc_err=0; o_bad_cnt=1.
REQ-037 Preamble 0x55,0x55,0x00,... -> DROP; zero beats; o_bad_cnt=1; next good frame -> o_good_cnt=1.
REQ-038 i_rst pulsed at frame byte 30 -> no beats for remainder; counters 0; following good frame -> 60 beats, o_good_cnt=1.
